// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
// Contents: FSM state encoding and the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold 0..width so it never wraps while counting bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/my_full_adder.sv
// rtl/my_full_adder.sv - 1-bit full adder cell
// Ports: a, b, c - addend bits and carry in; sum, carry - sum bit and carry out.
module my_full_adder (
    output logic sum,
    output logic carry,
    input  logic a,
    input  logic b,
    input  logic c
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder around one full adder cell
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   in_valid/in_ready      - operand handshake; op_a, op_b, carry_in sampled on it
//   out_valid/out_ready    - result handshake; result, carry_out valid with out_valid
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             cy_q, cy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] res_shift;

    my_full_adder u_fa (
        .sum   (fa_sum),
        .carry (fa_carry),
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .c     (cy_q)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift = (res_sr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        res_sr_d    = res_sr_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sr_d   = op_a;
                    b_sr_d   = op_b;
                    cy_d     = carry_in;
                    cnt_d    = '0;
                    res_sr_d = '0;
                    state_d  = ADD;
                end
            end
            ADD: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift;
                cy_d     = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                // Output registers update only here so they hold across IDLE
                // and the next operation until a new result is complete.
                if (cnt_q == LAST_CNT) begin
                    result_d    = res_shift;
                    carry_out_d = fa_carry;
                    state_d     = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            res_sr_q    <= '0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            res_sr_q    <= res_sr_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH 8 and 1
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       in_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       carry_in;
    logic       out_ready;

    logic       in_ready8, out_valid8, carry_out8;
    logic [7:0] result8;
    logic       in_ready1, out_valid1, carry_out1;
    logic [0:0] result1;

    logic       obs_in_ready, obs_out_valid, obs_cout;
    logic [7:0] obs_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid && !sel),
        .in_ready  (in_ready8),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
        .out_valid (out_valid8),
        .out_ready (out_ready && !sel),
        .result    (result8),
        .carry_out (carry_out8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid && sel),
        .in_ready  (in_ready1),
        .op_a      (op_a[0:0]),
        .op_b      (op_b[0:0]),
        .carry_in  (carry_in),
        .out_valid (out_valid1),
        .out_ready (out_ready && sel),
        .result    (result1),
        .carry_out (carry_out1)
    );

    assign obs_in_ready  = sel ? in_ready1  : in_ready8;
    assign obs_out_valid = sel ? out_valid1 : out_valid8;
    assign obs_cout      = sel ? carry_out1 : carry_out8;
    assign obs_result    = sel ? {7'b0, result1} : result8;

    // Drives one transaction and reports what was observed; callers do the checking.
    task automatic run_txn(input bit w1, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input int stall, input bit hold_valid,
                           output logic [7:0] res, output logic cout, output int lat,
                           output bit stable, output bit back_idle, output bit busy_low);
        int guard;
        sel = w1;
        @(negedge clk);
        op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1;
        out_ready = (stall == 0);
        guard = 0;
        while (!obs_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        busy_low = 1'b1;
        lat = 0;
        while (!obs_out_valid && lat < 100) begin
            busy_low &= !obs_in_ready;
            if (hold_valid) begin
                op_a = 8'($urandom); op_b = 8'($urandom); carry_in = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        busy_low &= !obs_in_ready;
        res = obs_result;
        cout = obs_cout;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            stable &= obs_out_valid && (obs_result === res) && (obs_cout === cout) && !obs_in_ready;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        back_idle = obs_in_ready && !obs_out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; carry_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready8); end
        n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid8); end
        n_checks++; if (result8 !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result8); end
        n_checks++; if (carry_out8 !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out got %b want 0", carry_out8); end
        n_checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_w1 got rdy=%b vld=%b want 1 0", in_ready1, out_valid1); end
    endtask

    task automatic test_directed();
        logic [7:0] res; logic cout; int lat; bit st, bi, bl;
        run_txn(1'b0, 8'h00, 8'h00, 1'b0, 0, 1'b0, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h00 || cout !== 1'b0) begin n_fail++; $display("FAIL zero_add got %b_%h want 0_00", cout, res); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL zero_latency got %0d want 8", lat); end
        n_checks++; if (bi !== 1'b1) begin n_fail++; $display("FAIL zero_back_idle got %b want 1", bi); end
        run_txn(1'b0, 8'hFF, 8'h01, 1'b0, 0, 1'b0, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h00 || cout !== 1'b1) begin n_fail++; $display("FAIL ff_plus_01 got %b_%h want 1_00", cout, res); end
        run_txn(1'b0, 8'h7F, 8'h01, 1'b0, 0, 1'b0, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h80 || cout !== 1'b0) begin n_fail++; $display("FAIL 7f_plus_01 got %b_%h want 0_80", cout, res); end
    endtask

    task automatic test_ignore_valid();
        logic [7:0] res; logic cout; int lat; bit st, bi, bl;
        run_txn(1'b0, 8'hA5, 8'h5A, 1'b1, 2, 1'b1, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h00 || cout !== 1'b1) begin n_fail++; $display("FAIL a5_5a_cin got %b_%h want 1_00", cout, res); end
        n_checks++; if (bl !== 1'b1 || st !== 1'b1) begin n_fail++; $display("FAIL busy_in_ready_low got busy=%b done=%b want 1 1", bl, st); end
        n_checks++; if (bi !== 1'b1) begin n_fail++; $display("FAIL hold_valid_back_idle got %b want 1", bi); end
    endtask

    task automatic test_backpressure();
        logic [7:0] res; logic cout; int lat; bit st, bi, bl;
        run_txn(1'b0, 8'h3C, 8'h0F, 1'b0, 5, 1'b0, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h4B || cout !== 1'b0) begin n_fail++; $display("FAIL bp_result got %b_%h want 0_4b", cout, res); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", st); end
        n_checks++; if (bi !== 1'b1) begin n_fail++; $display("FAIL bp_back_idle got %b want 1", bi); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] res; logic cout; int lat; bit st, bi, bl;
        int guard;
        sel = 1'b0;
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; carry_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        guard = 0;
        while (!in_ready8 && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin n_fail++; $display("FAIL abort_handshake got rdy=%b vld=%b want 1 0", in_ready8, out_valid8); end
        n_checks++; if (result8 !== 8'h00 || carry_out8 !== 1'b0) begin n_fail++; $display("FAIL abort_result got %b_%h want 0_00", carry_out8, result8); end
        run_txn(1'b0, 8'h01, 8'h01, 1'b0, 0, 1'b0, res, cout, lat, st, bi, bl);
        n_checks++; if (res !== 8'h02 || cout !== 1'b0) begin n_fail++; $display("FAIL after_abort got %b_%h want 0_02", cout, res); end
        n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL after_abort_latency got %0d want 8", lat); end
    endtask

    task automatic test_random(input bit w1);
        logic [7:0] a, b, res, exp_res; logic cin, cout, exp_cout;
        int lat, w, full, mask; bit st, bi, bl;
        w = w1 ? 1 : 8;
        mask = (1 << w) - 1;
        for (int n = 0; n < 500; n++) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            run_txn(w1, a, b, cin, $urandom_range(0, 3), 1'b0, res, cout, lat, st, bi, bl);
            full = (int'(a) & mask) + (int'(b) & mask) + int'(cin);
            exp_res = 8'(full & mask);
            exp_cout = 1'((full >> w) & 1);
            n_checks++; if (res !== exp_res || cout !== exp_cout) begin n_fail++; $display("FAIL rand_w%0d sum a=%h b=%h c=%b got %b_%h want %b_%h", w, a, b, cin, cout, res, exp_cout, exp_res); end
            n_checks++; if (lat !== w) begin n_fail++; $display("FAIL rand_w%0d latency got %0d want %0d", w, lat, w); end
            n_checks++; if (st !== 1'b1 || bi !== 1'b1 || bl !== 1'b1) begin n_fail++; $display("FAIL rand_w%0d handshake got stable=%b idle=%b busy=%b want 1 1 1", w, st, bi, bl); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_valid();
        test_backpressure();
        test_reset_abort();
        test_random(1'b0);
        test_random(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
